// File: rtl/chart_streamer.sv
// Chart replay source: buffers timestamped pattern entries loaded by the host,
// then emits each one as a single write pulse once game_timer comes within LOOKAHEAD.
module chart_streamer #(
   parameter int DEPTH      = 64,
   parameter int AW         = 6,
   parameter int LOOKAHEAD  = 4,
   parameter int GAP_CYCLES = 2
) (
   input  logic          CLOCK50M,
   input  logic          reset,
   input  logic          load_valid,
   input  logic [17:0]   load_data,
   output logic          load_ready,
   input  logic          clear,
   input  logic          start,
   input  logic          abort,
   input  logic [9:0]    game_timer,
   output logic          write,
   output logic [17:0]   pattern_with_timestamp,
   output logic          busy,
   output logic          done,
   output logic          order_err,
   output logic [AW:0]   count
);

   localparam int GW = $clog2(GAP_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, FETCH, CHECK, GAP, DONE} state_t;

   state_t        state;
   logic [AW:0]   rd_ptr;
   logic [9:0]    last_ts;
   logic [GW-1:0] gap_cnt;
   logic [17:0]   rd_data;
   logic [17:0]   mem [DEPTH];

   logic [9:0]  ld_ts;
   logic        in_order, load_fire, ram_we, due;
   logic [10:0] limit;

   assign load_ready = !reset && (state == IDLE) && (count < (AW+1)'(DEPTH));
   assign load_fire  = load_valid && load_ready;
   assign ld_ts      = load_data[17:8];
   assign in_order   = (count == '0) || (ld_ts >= last_ts);
   // start and clear both outrank a load offered in the same cycle
   assign ram_we     = load_fire && !start && !clear && in_order;
   assign limit      = {1'b0, game_timer} + 11'(LOOKAHEAD);
   assign due        = {1'b0, rd_data[17:8]} <= limit;

   // Chart storage is deliberately left out of reset.
   always_ff @(posedge CLOCK50M) begin
      if (ram_we)
         mem[count[AW-1:0]] <= load_data;
      if (state == FETCH)
         rd_data <= mem[rd_ptr[AW-1:0]];
   end

   always_ff @(posedge CLOCK50M) begin
      if (reset) begin
         state                  <= IDLE;
         count                  <= '0;
         rd_ptr                 <= '0;
         last_ts                <= '0;
         gap_cnt                <= '0;
         write                  <= 1'b0;
         pattern_with_timestamp <= '0;
         busy                   <= 1'b0;
         done                   <= 1'b0;
         order_err              <= 1'b0;
      end else begin
         write <= 1'b0;
         if (abort && state != IDLE) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     rd_ptr <= '0;
                     busy   <= 1'b1;
                     if (count != '0) begin
                        state <= FETCH;
                     end else begin
                        state <= DONE;
                        done  <= 1'b1;
                     end
                  end else if (clear) begin
                     count     <= '0;
                     last_ts   <= '0;
                     order_err <= 1'b0;
                  end else if (load_fire) begin
                     if (in_order) begin
                        count   <= count + 1'b1;
                        last_ts <= ld_ts;
                     end else begin
                        order_err <= 1'b1;
                     end
                  end
               end
               FETCH: state <= CHECK;
               CHECK: begin
                  // late entries satisfy the same compare, so they go out at once
                  if (due) begin
                     write                  <= 1'b1;
                     pattern_with_timestamp <= rd_data;
                     rd_ptr                 <= rd_ptr + 1'b1;
                     gap_cnt                <= '0;
                     state                  <= GAP;
                  end
               end
               GAP: begin
                  if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                     if (rd_ptr == count) begin
                        state <= DONE;
                        done  <= 1'b1;
                     end else begin
                        state <= FETCH;
                     end
                  end else begin
                     gap_cnt <= gap_cnt + 1'b1;
                  end
               end
               DONE: begin
                  if (start) begin
                     rd_ptr <= '0;
                     if (count != '0) begin
                        state <= FETCH;
                        done  <= 1'b0;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_chart_streamer.sv
// Directed bench for chart_streamer: a chart/queue model predicts load results and
// the ordered write stream; a per-cycle monitor compares the DUT against it.
module tb_chart_streamer;

   logic        clk = 1'b0;
   logic        reset, load_valid, clear, start, abort;
   logic [17:0] load_data;
   logic [9:0]  game_timer;
   logic        load_ready, write, busy, done, order_err;
   logic [17:0] pattern_with_timestamp;
   logic [6:0]  count;

   chart_streamer dut (
      .CLOCK50M(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
      .load_ready(load_ready), .clear(clear), .start(start), .abort(abort),
      .game_timer(game_timer), .write(write),
      .pattern_with_timestamp(pattern_with_timestamp), .busy(busy), .done(done),
      .order_err(order_err), .count(count)
   );

   always #5 clk = ~clk;

   int vectors = 0, fails = 0, cyc = 0;
   always @(posedge clk) cyc++;

   // model of the chart and of the host-visible control state
   logic [17:0] m_chart [64];
   int          m_count = 0;
   logic [9:0]  m_last = '0;
   logic        m_err = 1'b0, m_busy = 1'b0;
   logic [17:0] exp_q [$];
   logic [17:0] wr_log [$];
   int          wr_cyc [$];
   logic        chk_en = 1'b0, prev_wr = 1'b0;
   logic [9:0]  prev_gt = '0;
   int          st_cyc;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", busy, m_busy);
         chk("load_ready", load_ready, (!m_busy && m_count < 64));
         chk("count", count, m_count);
         chk("order_err", order_err, m_err);
         if (write) begin
            logic [17:0] d;
            chk("no_adjacent_write", prev_wr, 0);
            if (exp_q.size() == 0) begin
               chk("unexpected_write", 1, 0);
            end else begin
               d = exp_q.pop_front();
               chk("wdata", pattern_with_timestamp, d);
               chk("release_due", ({1'b0, d[17:8]} <= {1'b0, prev_gt} + 11'd4), 1);
            end
            wr_log.push_back(pattern_with_timestamp);
            wr_cyc.push_back(cyc);
         end
      end
      prev_wr = write;
      prev_gt = game_timer;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [17:0] d);
      load_valid = 1'b1; load_data = d;
      @(posedge clk);
      if (!m_busy && m_count < 64) begin
         if (m_count == 0 || d[17:8] >= m_last) begin
            m_chart[m_count] = d; m_count++; m_last = d[17:8];
         end else m_err = 1'b1;
      end
      #1 load_valid = 1'b0;
   endtask

   task automatic do_clear(input logic with_load);
      clear = 1'b1; load_valid = with_load; load_data = 18'h00F00;
      @(posedge clk);
      m_count = 0; m_last = '0; m_err = 1'b0;
      #1 clear = 1'b0; load_valid = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk);
      if (!m_busy) begin
         m_busy = 1'b1;
         for (int i = 0; i < m_count; i++) exp_q.push_back(m_chart[i]);
      end
      #1 start = 1'b0;
      st_cyc = cyc;
   endtask

   task automatic do_abort();
      abort = 1'b1; exp_q.delete();
      @(posedge clk);
      m_busy = 1'b0;
      #1 abort = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string nm);
      for (int i = 0; i < budget && !done; i++) step(1);
      chk(nm, done, 1);
   endtask

   task automatic wait_writes(input int n, input int budget, input string nm);
      for (int i = 0; i < budget && wr_log.size() < n; i++) step(1);
      chk(nm, (wr_log.size() >= n), 1);
   endtask

   initial begin
      reset = 1'b1; load_valid = 1'b0; load_data = '0; clear = 1'b0;
      start = 1'b0; abort = 1'b0; game_timer = '0;
      step(3);
      chk("rst_write", write, 0);
      chk("rst_pwt", pattern_with_timestamp, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_order_err", order_err, 0);
      chk("rst_count", count, 0);
      chk("rst_load_ready", load_ready, 0);
      reset = 1'b0;
      step(1);
      chk_en = 1'b1;

      // ts 5,5,9 held at timer 0, then released in two steps
      load(18'h00501); load(18'h00502); load(18'h00904);
      chk("A_count", count, 3);
      wr_log.delete(); wr_cyc.delete();
      do_start();
      step(8);
      chk("A_held_at_t0", wr_log.size(), 0);
      game_timer = 10'd1;
      wait_writes(2, 20, "A_two_writes");
      step(4);
      chk("A_third_held", wr_log.size(), 2);
      game_timer = 10'd5;
      wait_done(20, "A_done");
      chk("A_nwrites", wr_log.size(), 3);
      chk("A_w0", wr_log[0], 18'h00501);
      chk("A_w1", wr_log[1], 18'h00502);
      chk("A_w2", wr_log[2], 18'h00904);
      chk("A_spacing", wr_cyc[1] - wr_cyc[0], 4);
      do_abort();

      // out-of-order drop, then clear (with a same-cycle load that must be ignored)
      do_clear(1'b0);
      load(18'h00A11); load(18'h00322);
      chk("B_count", count, 1);
      chk("B_order_err", order_err, 1);
      do_clear(1'b1);
      step(1);
      chk("B_clr_count", count, 0);
      chk("B_clr_err", order_err, 0);

      // empty start goes straight to DONE
      wr_log.delete();
      do_start();
      chk("C_done", done, 1);
      step(5);
      chk("C_no_write", wr_log.size(), 0);
      do_abort();
      chk("C_idle_busy", busy, 0);

      // fill to capacity, overflow offer, full replay with everything late
      for (int i = 0; i < 64; i++) load({10'(i * 16), 8'(i)});
      chk("D_full_count", count, 64);
      chk("D_full_ready", load_ready, 0);
      load(18'h3FFAA);
      chk("D_no_65th", count, 64);
      game_timer = 10'd1023;
      wr_log.delete(); wr_cyc.delete();
      do_start();
      wait_done(400, "D_done");
      chk("D_nwrites", wr_log.size(), 64);
      chk("D_last", wr_log[63], 18'h3F03F);
      do_abort();

      // abort in GAP after two of three writes, then full restart from entry 0
      do_clear(1'b0);
      load(18'h00011); load(18'h00112); load(18'h00213);
      game_timer = 10'd100;
      wr_log.delete(); wr_cyc.delete();
      do_start();
      wait_writes(2, 40, "E_two_writes");
      chk("E_latency", wr_cyc[0] - st_cyc, 2);
      do_abort();
      chk("E_busy", busy, 0);
      chk("E_done", done, 0);
      step(10);
      chk("E_no_more", wr_log.size(), 2);
      do_start();
      wait_done(60, "E_done_again");
      chk("E_nwrites", wr_log.size(), 5);
      chk("E_restart_w0", wr_log[2], 18'h00011);
      do_abort();

      // reset while CHECK holds a due entry
      do_clear(1'b0);
      load(18'h00811); load(18'h00222);
      do_start();
      step(1);
      reset = 1'b1; exp_q.delete(); chk_en = 1'b0;
      step(1);
      m_count = 0; m_last = '0; m_err = 1'b0; m_busy = 1'b0;
      chk("F_write", write, 0);
      chk("F_pwt", pattern_with_timestamp, 0);
      chk("F_busy", busy, 0);
      chk("F_done", done, 0);
      chk("F_order_err", order_err, 0);
      chk("F_count", count, 0);
      chk("F_load_ready", load_ready, 0);
      reset = 1'b0;
      step(1);
      chk_en = 1'b1;
      step(3);
      chk("F_ready_after", load_ready, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
